// File: rtl/status_link_arbiter.sv
// status_link_arbiter: shares one serial status link between N_REQ message
// sources. Requester 0 (alarms) has absolute priority and the remaining
// requesters share the link round-robin. Each winning payload is framed with
// its source ID, shifted out MSB-first and followed by a standby gap.
module status_link_arbiter #(
  parameter int N_REQ = 3,
  parameter int MSG_W = 4,
  parameter int ID_W  = 2,
  parameter int SB    = 3
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [N_REQ-1:0]       REQ,
  input  logic [N_REQ*MSG_W-1:0] MSG,
  output logic [N_REQ-1:0]       GNT,
  output logic                   BUSY,
  output logic                   STATUS_SEND,
  output logic                   STATUS_OUT,
  output logic                   FRAME_DONE
);

  localparam int F  = ID_W + MSG_W;
  localparam int CW = $clog2(F);
  localparam int GW = (SB < 2) ? 1 : $clog2(SB + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [F-1:0]      sh_q, sh_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic              busy_q, busy_d;
  logic              send_q, send_d;
  logic              out_q, out_d;
  logic              done_q, done_d;

  logic              win_valid;
  logic [ID_W-1:0]   win_idx;
  logic [MSG_W-1:0]  msg_slice [N_REQ];

  // Unpack the flat payload bus into one slice per requester.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
    assign msg_slice[gi] = MSG[gi*MSG_W +: MSG_W];
  end

  // Winner selection: requester 0 first, otherwise the first set request
  // found walking 1..N_REQ-1 from the pointer with wrap-around.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    if (REQ[0]) begin
      win_valid = 1'b1;
    end else begin
      for (int k = 0; k < N_REQ - 1; k++) begin
        if (!win_valid && REQ[((int'(ptr_q) - 1 + k) % (N_REQ - 1)) + 1]) begin
          win_valid = 1'b1;
          win_idx   = ID_W'(((int'(ptr_q) - 1 + k) % (N_REQ - 1)) + 1);
        end
      end
    end
  end

  // Next-state logic for the IDLE -> SHIFT -> (GAP) -> IDLE frame sequence.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    sh_d    = sh_q;
    gnt_d   = '0;
    busy_d  = busy_q;
    send_d  = send_q;
    out_d   = out_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        send_d = 1'b0;
        out_d  = 1'b0;
        if (win_valid) begin
          // The payload is captured here; later MSG changes cannot leak in.
          gnt_d   = N_REQ'(1) << win_idx;
          sh_d    = {win_idx, msg_slice[win_idx]};
          send_d  = 1'b1;
          out_d   = win_idx[ID_W-1];
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = SHIFT;
          // Alarm wins leave the round-robin position of the others alone.
          if (win_idx != '0) begin
            if (win_idx == ID_W'(N_REQ - 1)) ptr_d = ID_W'(1);
            else                             ptr_d = win_idx + 1'b1;
          end
        end
      end
      SHIFT: begin
        if (cnt_q == CW'(F - 1)) begin
          send_d = 1'b0;
          out_d  = 1'b0;
          done_d = 1'b1;
          if (SB > 0) begin
            // The FRAME_DONE cycle already counts as the first gap cycle.
            gap_d   = GW'(1);
            state_d = GAP;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          sh_d  = sh_q << 1;
          out_d = sh_q[F-2];
        end
      end
      GAP: begin
        if (gap_q >= GW'(SB)) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        send_d  = 1'b0;
        out_d   = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset aborts any frame in flight.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      ptr_q   <= ID_W'(1);
      cnt_q   <= '0;
      gap_q   <= '0;
      sh_q    <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      send_q  <= 1'b0;
      out_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      sh_q    <= sh_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      send_q  <= send_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  assign GNT         = gnt_q;
  assign BUSY        = busy_q;
  assign STATUS_SEND = send_q;
  assign STATUS_OUT  = out_q;
  assign FRAME_DONE  = done_q;

endmodule

// File: tb/tb_status_link_arbiter.sv
// Bench for status_link_arbiter: a default build (SB=3) and an SB=0 build
// share clock and reset. Expected frames are queued when stimulus is applied
// and checked by a per-cycle monitor as each frame leaves the link.
module tb_status_link_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0]  req_s  [2];
  logic [11:0] msg_s  [2];
  logic [2:0]  gnt_s  [2];
  logic        busy_s [2];
  logic        send_s [2];
  logic        out_s  [2];
  logic        done_s [2];

  always #5 clk = ~clk;

  status_link_arbiter #(.N_REQ(3), .MSG_W(4), .ID_W(2), .SB(3)) dut_a (
    .CLK(clk), .RST(rst_n), .REQ(req_s[0]), .MSG(msg_s[0]), .GNT(gnt_s[0]),
    .BUSY(busy_s[0]), .STATUS_SEND(send_s[0]), .STATUS_OUT(out_s[0]),
    .FRAME_DONE(done_s[0])
  );

  status_link_arbiter #(.N_REQ(3), .MSG_W(4), .ID_W(2), .SB(0)) dut_b (
    .CLK(clk), .RST(rst_n), .REQ(req_s[1]), .MSG(msg_s[1]), .GNT(gnt_s[1]),
    .BUSY(busy_s[1]), .STATUS_SEND(send_s[1]), .STATUS_OUT(out_s[1]),
    .FRAME_DONE(done_s[1])
  );

  typedef struct {
    int         dut;
    logic [2:0] gnt;
    logic [5:0] frame;
    int         period;
  } exp_t;

  typedef struct {
    logic [2:0]  req;
    logic [11:0] msg;
    logic [2:0]  gnt;
    logic [5:0]  frame;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[10];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bit         act    [2];
  int         len    [2];
  logic [5:0] bits   [2];
  logic [2:0] fgnt   [2];
  int         gcyc   [2];
  int         prevg  [2];
  int         gpulse [2];
  int         gcount [2];
  bit         gapon  [2];
  int         gapn   [2];

  function automatic int sb_of(input int d);
    return (d == 0) ? 3 : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act_v, exp_v);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  // Per-cycle observation of one DUT: grants, serial bits, frame end, gap.
  task automatic monitor(input int d);
    exp_t e;
    if (!rst_n) begin
      act[d] = 1'b0; gapon[d] = 1'b0; gpulse[d] = 0; prevg[d] = -1;
      return;
    end
    if (gnt_s[d] != 3'b000) begin
      gcount[d]++;
      gpulse[d]++;
      fgnt[d] = gnt_s[d];
      gcyc[d] = cyc;
      chk($sformatf("send_with_gnt[%0d]", d), 32'(send_s[d]), 32'd1);
    end
    if (send_s[d]) begin
      if (!act[d]) begin act[d] = 1'b1; len[d] = 0; bits[d] = '0; end
      bits[d] = {bits[d][4:0], out_s[d]};
      len[d]++;
    end else if (act[d]) begin
      act[d] = 1'b0;
      if (exp_q.size() == 0) begin
        fail_now($sformatf("unexpected_frame[%0d]", d));
      end else begin
        e = exp_q.pop_front();
        $display("frame dut%0d gnt=%b bits=%b len=%0d (exp gnt=%b bits=%b)",
                 d, fgnt[d], bits[d], len[d], e.gnt, e.frame);
        chk("frame_dut", 32'(d), 32'(e.dut));
        chk("frame_gnt", 32'(fgnt[d]), 32'(e.gnt));
        chk("frame_bits", 32'(bits[d]), 32'(e.frame));
        chk("frame_len", 32'(len[d]), 32'd6);
        chk("frame_done", 32'(done_s[d]), 32'd1);
        chk("out_idle_low", 32'(out_s[d]), 32'd0);
        chk("gnt_one_cycle", 32'(gpulse[d]), 32'd1);
        if (e.period != 0)
          chk("grant_period", 32'(gcyc[d] - prevg[d]), 32'(e.period));
      end
      prevg[d]  = gcyc[d];
      gpulse[d] = 0;
      gapon[d]  = 1'b1;
      gapn[d]   = 0;
    end
    if (gapon[d]) begin
      if (busy_s[d]) gapn[d]++;
      else begin
        gapon[d] = 1'b0;
        chk($sformatf("gap_len[%0d]", d), 32'(gapn[d]), 32'(sb_of(d)));
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    monitor(0);
    monitor(1);
  endtask

  task automatic wait_grant(input int d);
    int n;
    n = 0;
    do begin tick(); n++; end while (gnt_s[d] == 3'b000 && n < 40);
    if (gnt_s[d] == 3'b000) fail_now($sformatf("wait_grant[%0d]", d));
  endtask

  task automatic wait_grants(input int d, input int target);
    int n;
    n = 0;
    while (gcount[d] < target && n < 200) begin tick(); n++; end
    if (gcount[d] < target) fail_now($sformatf("wait_grants[%0d]", d));
  endtask

  task automatic wait_quiet(input int d);
    int n;
    n = 0;
    do begin tick(); n++; end
    while ((busy_s[d] || send_s[d] || gapon[d]) && n < 60);
    if (busy_s[d] || send_s[d] || gapon[d]) fail_now($sformatf("wait_quiet[%0d]", d));
  endtask

  initial begin
    int   base;
    bit   seen;
    int   n;
    for (int d = 0; d < 2; d++) begin
      req_s[d] = '0; msg_s[d] = '0; act[d] = 1'b0; gapon[d] = 1'b0;
      gcount[d] = 0; gpulse[d] = 0; prevg[d] = -1; len[d] = 0; gapn[d] = 0;
    end

    // Hand-derived vectors; pointer starts at 1 after reset.
    vecs[0] = '{3'b010, 12'b0000_1011_0000, 3'b010, 6'b01_1011};
    vecs[1] = '{3'b110, 12'b1100_0011_0000, 3'b100, 6'b10_1100};
    vecs[2] = '{3'b110, 12'b1100_0011_0000, 3'b010, 6'b01_0011};
    vecs[3] = '{3'b101, 12'b0001_0000_1111, 3'b001, 6'b00_1111};
    vecs[4] = '{3'b110, 12'b0110_0000_0000, 3'b100, 6'b10_0110};
    vecs[5] = '{3'b100, 12'b1001_0000_0000, 3'b100, 6'b10_1001};
    vecs[6] = '{3'b111, 12'b1111_1111_0000, 3'b001, 6'b00_0000};
    vecs[7] = '{3'b011, 12'b0000_0101_1010, 3'b001, 6'b00_1010};
    vecs[8] = '{3'b010, 12'b0000_0101_0000, 3'b010, 6'b01_0101};
    vecs[9] = '{3'b100, 12'b0111_0000_0000, 3'b100, 6'b10_0111};

    // Reset state of both builds.
    rst_n = 1'b0;
    tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_gnt[%0d]", d),  32'(gnt_s[d]),  32'd0);
      chk($sformatf("reset_busy[%0d]", d), 32'(busy_s[d]), 32'd0);
      chk($sformatf("reset_send[%0d]", d), 32'(send_s[d]), 32'd0);
      chk($sformatf("reset_out[%0d]", d),  32'(out_s[d]),  32'd0);
      chk($sformatf("reset_done[%0d]", d), 32'(done_s[d]), 32'd0);
    end
    rst_n = 1'b1;

    // Single-frame vectors: drop REQ as soon as the grant is seen.
    for (int i = 0; i < 10; i++) begin
      req_s[0] = vecs[i].req;
      msg_s[0] = vecs[i].msg;
      exp_q.push_back('{0, vecs[i].gnt, vecs[i].frame, 0});
      wait_grant(0);
      req_s[0] = 3'b000;
      wait_quiet(0);
    end

    // All requests held: requester 0 starves the rest, then 1/2 alternate.
    msg_s[0] = 12'b0100_0010_0001;
    exp_q.push_back('{0, 3'b001, 6'b00_0001, 0});
    exp_q.push_back('{0, 3'b001, 6'b00_0001, 10});
    exp_q.push_back('{0, 3'b001, 6'b00_0001, 10});
    exp_q.push_back('{0, 3'b010, 6'b01_0010, 10});
    exp_q.push_back('{0, 3'b100, 6'b10_0100, 10});
    exp_q.push_back('{0, 3'b010, 6'b01_0010, 10});
    exp_q.push_back('{0, 3'b100, 6'b10_0100, 10});
    base = gcount[0];
    req_s[0] = 3'b111;
    wait_grants(0, base + 3);
    req_s[0] = 3'b110;
    wait_grants(0, base + 7);
    req_s[0] = 3'b000;
    wait_quiet(0);

    // Request raised mid-frame waits for IDLE; in-flight payload is frozen.
    msg_s[0] = 12'b0011_1100_0000;
    exp_q.push_back('{0, 3'b010, 6'b01_1100, 0});
    exp_q.push_back('{0, 3'b100, 6'b10_0011, 10});
    req_s[0] = 3'b010;
    wait_grant(0);
    req_s[0] = 3'b000;
    tick();
    tick();
    req_s[0] = 3'b100;
    msg_s[0] = 12'b0011_0001_0000;
    wait_grant(0);
    req_s[0] = 3'b000;
    wait_quiet(0);

    // Asynchronous reset during bit 3 aborts the frame and resets the pointer.
    msg_s[0] = 12'b0000_0100_0000;
    req_s[0] = 3'b010;
    wait_grant(0);
    req_s[0] = 3'b000;
    tick();
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_send", 32'(send_s[0]), 32'd0);
    chk("async_rst_out",  32'(out_s[0]),  32'd0);
    chk("async_rst_busy", 32'(busy_s[0]), 32'd0);
    chk("async_rst_gnt",  32'(gnt_s[0]),  32'd0);
    chk("async_rst_done", 32'(done_s[0]), 32'd0);
    req_s[0] = 3'b110;
    msg_s[0] = 12'b1010_0110_0000;
    tick();
    rst_n = 1'b1;
    exp_q.push_back('{0, 3'b010, 6'b01_0110, 0});
    wait_grant(0);
    req_s[0] = 3'b000;
    wait_quiet(0);

    // SB=0 build with REQ[1] held: grants every 7 cycles.
    msg_s[1] = 12'b0000_1101_0000;
    exp_q.push_back('{1, 3'b010, 6'b01_1101, 0});
    exp_q.push_back('{1, 3'b010, 6'b01_1101, 7});
    exp_q.push_back('{1, 3'b010, 6'b01_1101, 7});
    base = gcount[1];
    req_s[1] = 3'b010;
    wait_grants(1, base + 3);
    req_s[1] = 3'b000;
    wait_quiet(1);

    // A one-cycle request inside the gap is withdrawn before IDLE.
    msg_s[0] = 12'b0000_1110_0000;
    exp_q.push_back('{0, 3'b010, 6'b01_1110, 0});
    req_s[0] = 3'b010;
    wait_grant(0);
    req_s[0] = 3'b000;
    n = 0;
    do begin tick(); n++; end while (!done_s[0] && n < 20);
    if (!done_s[0]) fail_now("wait_frame_done");
    req_s[0] = 3'b010;
    tick();
    req_s[0] = 3'b000;
    base = gcount[0];
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (send_s[0]) seen = 1'b1;
    end
    chk("gap_pulse_no_grant", 32'(gcount[0]), 32'(base));
    chk("gap_pulse_no_send",  32'(seen),      32'd0);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
